// File: rtl/tdm_mux8_tx.sv
// tdm_mux8_tx: 8-channel time-division multiplexing transmitter.
// A start request snapshots channels a..h and shifts them out one per slot
// on y, with the slot number on s so the receiving demux can route each bit.
// Frames can chain back-to-back, and en stalls slot advance.
module tdm_mux8_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       en,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic       h,
    output logic       y,
    output logic [2:0] s,
    output logic       frame,
    output logic       last,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t     state_reg;
    logic [7:0] snap_reg;
    logic [2:0] slot_reg;
    logic       y_reg;
    logic       frame_reg;
    logic       last_reg;
    logic       busy_reg;

    // Channel a is bit 0, so the frame goes out LSB first.
    logic [7:0] chan;
    logic [2:0] slot_inc;

    assign chan     = {h, g, f, e, d, c, b, a};
    assign slot_inc = slot_reg + 3'd1;

    // Frame sequencer: every output is computed one edge ahead and registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            snap_reg  <= 8'h00;
            slot_reg  <= 3'd0;
            y_reg     <= 1'b0;
            frame_reg <= 1'b0;
            last_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // en is not needed to open a frame.
                    if (start) begin
                        state_reg <= SEND;
                        snap_reg  <= chan;
                        slot_reg  <= 3'd0;
                        y_reg     <= chan[0];
                        frame_reg <= 1'b1;
                        last_reg  <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end
                SEND: begin
                    // With en low everything holds, and start is dropped
                    // rather than queued.
                    if (en) begin
                        if (slot_reg != 3'd7) begin
                            slot_reg  <= slot_inc;
                            y_reg     <= snap_reg[slot_inc];
                            frame_reg <= 1'b0;
                            last_reg  <= (slot_inc == 3'd7);
                        end else if (start) begin
                            // Chained frame: slot 0 follows slot 7 with no gap.
                            snap_reg  <= chan;
                            slot_reg  <= 3'd0;
                            y_reg     <= chan[0];
                            frame_reg <= 1'b1;
                            last_reg  <= 1'b0;
                        end else begin
                            state_reg <= IDLE;
                            slot_reg  <= 3'd0;
                            y_reg     <= 1'b0;
                            frame_reg <= 1'b0;
                            last_reg  <= 1'b0;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign y     = y_reg;
    assign s     = slot_reg;
    assign frame = frame_reg;
    assign last  = last_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_tdm_mux8_tx.sv
// Testbench for tdm_mux8_tx: a frame-level model is compared against the DUT
// every cycle, and directed scenarios pin expected values by hand.
module tb_tdm_mux8_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       en = 1'b1;
    logic [7:0] ins = 8'h00;
    logic       y;
    logic [2:0] s;
    logic       frame;
    logic       last;
    logic       busy;

    int errors = 0;
    int checks = 0;

    tdm_mux8_tx dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .en    (en),
        .a     (ins[0]),
        .b     (ins[1]),
        .c     (ins[2]),
        .d     (ins[3]),
        .e     (ins[4]),
        .f     (ins[5]),
        .g     (ins[6]),
        .h     (ins[7]),
        .y     (y),
        .s     (s),
        .frame (frame),
        .last  (last),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: whether a frame is in flight, its captured word,
    // and how many slots of it have been sent.
    logic       m_active = 1'b0;
    logic [7:0] m_word = 8'h00;
    int         m_slot = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_word   <= 8'h00;
            m_slot   <= 0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_word   <= ins;
                m_slot   <= 0;
            end
        end else if (en) begin
            if (m_slot < 7) begin
                m_slot <= m_slot + 1;
            end else if (start) begin
                m_word <= ins;
                m_slot <= 0;
            end else begin
                m_active <= 1'b0;
                m_slot   <= 0;
            end
        end
    end

    // Every-cycle comparison on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("model_busy", {7'd0, busy}, {7'd0, m_active});
            chk("model_s", {5'd0, s}, m_active ? 8'(m_slot) : 8'd0);
            chk("model_y", {7'd0, y}, m_active ? {7'd0, m_word[m_slot]} : 8'd0);
            chk("model_frame", {7'd0, frame}, {7'd0, m_active && m_slot == 0});
            chk("model_last", {7'd0, last}, {7'd0, m_active && m_slot == 7});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_y"}, {7'd0, y}, 8'd0);
        chk({name, "_s"}, {5'd0, s}, 8'd0);
        chk({name, "_frame"}, {7'd0, frame}, 8'd0);
        chk({name, "_last"}, {7'd0, last}, 8'd0);
        chk({name, "_busy"}, {7'd0, busy}, 8'd0);
    endtask

    logic [7:0] pat;
    int         stall_s [11] = '{0, 1, 2, 3, 4, 4, 4, 4, 5, 6, 7};

    initial begin
        // Reset before any clock edge, with arbitrary inputs and start high.
        ins = 8'hC3; start = 1'b1; en = 1'b1;
        #1 rst = 1'b1;
        #1 chk_idle("reset_async");
        tick(); tick();
        chk_idle("reset_wins");
        rst = 1'b0; start = 1'b0;
        tick();
        chk_idle("idle_after_reset");
        $display("txn reset: outputs idle");

        // Single frame, 8'b1011_0010.
        pat = 8'b1011_0010;
        ins = pat; start = 1'b1; en = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("single_s", {5'd0, s}, 8'(k));
            chk("single_y", {7'd0, y}, {7'd0, pat[k]});
            chk("single_frame", {7'd0, frame}, {7'd0, k == 0});
            chk("single_last", {7'd0, last}, {7'd0, k == 7});
            chk("single_busy", {7'd0, busy}, 8'd1);
            tick();
        end
        chk("single_end_busy", {7'd0, busy}, 8'd0);
        $display("txn single frame 8'hb2 sent");

        // Snapshot isolation: inputs change at slot 2.
        pat = 8'hA5;
        ins = pat; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) ins = 8'h5A;
            chk("snap_y", {7'd0, y}, {7'd0, pat[k]});
            tick();
        end
        chk("snap_end_busy", {7'd0, busy}, 8'd0);
        $display("txn snapshot isolation 8'ha5 sent");

        // Back-to-back: FF frame then 00 frame, no gap.
        ins = 8'hFF; start = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            if (k == 7) ins = 8'h00;
            if (k == 15) start = 1'b0;
            chk("b2b_y", {7'd0, y}, {7'd0, k < 8});
            chk("b2b_s", {5'd0, s}, 8'(k % 8));
            chk("b2b_frame", {7'd0, frame}, {7'd0, (k % 8) == 0});
            chk("b2b_busy", {7'd0, busy}, 8'd1);
            tick();
        end
        chk("b2b_end_busy", {7'd0, busy}, 8'd0);
        $display("txn back-to-back ff/00 sent");

        // Stall three edges on slot 4, ignored start at slot 5.
        pat = 8'h3C;
        ins = pat; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 11; c++) begin
            if (c == 4) en = 1'b0;
            if (c == 7) en = 1'b1;
            if (c == 8) start = 1'b1;
            if (c == 9) start = 1'b0;
            chk("stall_s", {5'd0, s}, 8'(stall_s[c]));
            chk("stall_y", {7'd0, y}, {7'd0, pat[stall_s[c]]});
            tick();
        end
        chk("stall_end_busy", {7'd0, busy}, 8'd0);
        tick();
        chk("stall_no_extra", {7'd0, busy}, 8'd0);
        $display("txn stall and ignored start done");

        // Reset mid-frame at slot 3.
        ins = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("abort_pre_s", {5'd0, s}, 8'd3);
        #1 rst = 1'b1;
        #1 chk_idle("abort_async");
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("abort_stay_idle", {7'd0, busy}, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_s", {5'd0, s}, 8'd0);
        chk("restart_frame", {7'd0, frame}, 8'd1);
        chk("restart_busy", {7'd0, busy}, 8'd1);
        chk("restart_y", {7'd0, y}, 8'd1);
        for (int k = 0; k < 8; k++) tick();
        chk("restart_end_busy", {7'd0, busy}, 8'd0);
        $display("txn reset mid-frame and restart done");

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tdm_mux8_tx.md
# tdm_mux8_tx

Time-division multiplexing transmitter: the sending end of the 8-channel select link whose receiving end is the 1x8 demux. On `start` it snapshots eight single-bit channel inputs (`a`..`h`) and drives them one per slot onto serial line `y`. It presents the matching 3-bit slot select `s` so a downstream demux routes each bit back to its channel. Frames can run back-to-back, and slot advance can be stalled with `en`.

## Interface

Parameters:
- none; channel count fixed at 8, select width fixed at 3.

Ports:
- `clk`    input   1  system clock, rising-edge.
- `rst`    input   1  reset, asynchronous, active-high.
- `start`  input   1  request a frame; sampled on rising edge.
- `en`     input   1  slot-advance enable; low stalls the active frame.
- `a`..`h` input   1 each  channel inputs; `a` = channel 0 … `h` = channel 7.
- `y`      output  1  serial data for the current slot.
- `s`      output  3  current slot number; equals the channel index carried on `y`.
- `frame`  output  1  high while slot 0 is presented (frame sync).
- `last`   output  1  high while slot 7 is presented.
- `busy`   output  1  high while a frame is active.

## Operation

- State machine with two states.
  - IDLE: `busy`=0, `y`=0, `s`=0, `frame`=0, `last`=0.
  - SEND: `busy`=1.
- Snapshot: an 8-bit register captures {`h`,`g`,`f`,`e`,`d`,`c`,`b`,`a`} on the edge that starts a frame. Inputs changing mid-frame have no effect on that frame.
- IDLE -> SEND: on an edge with `start`=1.
  - Capture the snapshot.
  - Set slot counter to 0.
  - `en` is not required for this transition.
- In SEND: `y` = snapshot[slot], `s` = slot, `frame` = (slot==0), `last` = (slot==7).
- Edge in SEND with `en`=1 and slot<7: slot increments by 1.
- Edge in SEND with `en`=0: slot, `y`, and the snapshot hold.
- Edge in SEND with `en`=1 and slot==7:
  - If `start`=1: recapture the snapshot, slot wraps to 0, stay in SEND. Back-to-back frame with no gap.
  - If `start`=0: go to IDLE.
- `start` in SEND at any other point (slot<7, or `en`=0) is ignored. It is not queued.
- Slot counter is 3-bit and never exceeds 7. Wrap occurs only via the back-to-back rule.
- All outputs are registered (no combinational path from inputs to outputs).

## Timing

- Reset: `rst`=1 forces IDLE immediately, without waiting for a clock edge.
  - `y`=0, `s`=3'b000, `frame`=0, `last`=0, `busy`=0, snapshot cleared to 0.
  - Reset mid-frame aborts the frame. No `last` is emitted.
- First edge with `rst`=0 and `start`=1 starts a frame.
- Latency: `start` sampled at edge N -> slot 0 visible after edge N, `frame`=1.
- Unstalled frame: slots 0..7 occupy 8 consecutive cycles. `busy` drops after the edge that ends slot 7, unless chained.
- Chained frames: slot 7 of frame k is followed immediately by slot 0 of frame k+1. `busy` stays 1; `frame` pulses again.
- A stall of M cycles (`en`=0) lengthens the current slot by M cycles. `frame` or `last` stays asserted throughout a stall on slot 0 or slot 7.
- Simultaneous `rst` and `start`: reset wins.

## Test plan

- Reset: assert `rst` with arbitrary inputs -> `y`=0, `s`=0, `busy`=0, `frame`=0, `last`=0, all before any clock edge.
- Single frame: {`h`..`a`}=8'b1011_0010, pulse `start`, `en`=1.
  - Next 8 cycles: `s`=0..7 and `y`=0,1,0,0,1,1,0,1.
  - `frame` is high only in cycle 1; `last` is high only in cycle 8.
  - `busy`=0 in cycle 9.
- Snapshot isolation: start with inputs 8'hA5, change inputs to 8'h5A at slot 2 -> `y` sequence still follows 8'hA5 (LSB first).
- Back-to-back frames: hold `start`=1, inputs 8'hFF then 8'h00 at the second capture edge.
  - 16 contiguous slots: eight 1s then eight 0s.
  - `s` wraps 7->0 with no gap; `frame` pulses at cycles 1 and 9.
- Stall plus ignored start: drop `en` for 3 cycles at slot 4 and pulse `start` at slot 5.
  - `s`=4 and `y` hold for 4 cycles total.
  - The frame ends after slot 7 with no extra frame.
- Reset mid-frame: assert `rst` at slot 3 -> outputs go to reset values immediately.
  - With `start`=0 after release, it stays IDLE.
  - A later `start` begins cleanly at slot 0.
